// File: rtl/adder_tree_sched.sv
// adder_tree_sched: round-robin scheduler sharing one fixed-latency fp32 adder
// tree among NUM_REQ requesters. Issued vectors carry their requester ID down a
// tag pipeline matched to the tree latency; sums land in a FWFT result FIFO.
// Issue is credit-limited (inflight + fifo_count < FIFO_DEPTH), so a tree
// result always has a FIFO slot waiting for it.
module adder_tree_sched #(
    parameter int NUM_REQ    = 4,
    parameter int NUM_IN     = 8,
    parameter int DW_DATA    = 32,
    parameter int DW_IN      = NUM_IN * DW_DATA,
    parameter int TREE_LAT   = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DW_IN-1:0]   req_data,
    output logic [DW_IN-1:0]           tree_in,
    input  logic [DW_DATA-1:0]         tree_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DW_DATA-1:0]         res_data,
    output logic [ID_W-1:0]            res_id,
    output logic                       busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

    // Registered state
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [DW_IN-1:0]   tree_in_q, tree_in_d;
    logic [TREE_LAT:0]  tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]    tag_id_q [TREE_LAT+1];
    logic [ID_W-1:0]    tag_id_d [TREE_LAT+1];
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic [CNT_W-1:0]   fifo_count_q, fifo_count_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DW_DATA-1:0] mem_data_q [FIFO_DEPTH];
    logic [ID_W-1:0]    mem_id_q   [FIFO_DEPTH];

    // Combinational control
    logic               eligible;
    logic               grant_found;
    logic               grant;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    cand;
    logic               fifo_wr;
    logic               fifo_rd;

    // Round-robin search starting one past the last granted index, gated by credits.
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = ptr_q;
        cand        = ptr_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        // Registered counts only: a pop this cycle frees its credit next cycle.
        eligible = ({1'b0, inflight_q} + {1'b0, fifo_count_q}) < CREDIT_LIMIT;
        // Held low in reset so no requester sees a handshake that is then discarded.
        grant    = grant_found && eligible && !rst;
        for (int r = 0; r < NUM_REQ; r++) begin
            req_ready[r] = grant && (grant_idx == ID_W'(r));
        end
    end

    // Next-state for operand register, tag pipeline, credits and FIFO pointers.
    always_comb begin
        tree_in_d = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (req_ready[r]) begin
                tree_in_d = req_data[r*DW_IN +: DW_IN];
            end
        end
        ptr_d = grant ? grant_idx : ptr_q;

        tag_vld_d   = {tag_vld_q[TREE_LAT-1:0], grant};
        tag_id_d[0] = grant_idx;
        for (int j = 1; j <= TREE_LAT; j++) begin
            tag_id_d[j] = tag_id_q[j-1];
        end

        // The tag leaving the last stage lines up with the sum on tree_out.
        fifo_wr = tag_vld_q[TREE_LAT];
        fifo_rd = res_valid && res_ready;

        inflight_d   = inflight_q + CNT_W'(grant) - CNT_W'(fifo_wr);
        fifo_count_d = fifo_count_q + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);

        wr_ptr_d = wr_ptr_q;
        if (fifo_wr) begin
            wr_ptr_d = (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        rd_ptr_d = rd_ptr_q;
        if (fifo_rd) begin
            rd_ptr_d = (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
    end

    // Control state with synchronous reset; reset drops every tag and FIFO entry.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= ID_W'(NUM_REQ - 1);
            tree_in_q    <= '0;
            tag_vld_q    <= '0;
            inflight_q   <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            ptr_q        <= ptr_d;
            tree_in_q    <= tree_in_d;
            tag_vld_q    <= tag_vld_d;
            inflight_q   <= inflight_d;
            fifo_count_q <= fifo_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            assert (!(fifo_wr && (fifo_count_q == CNT_W'(FIFO_DEPTH))))
                else $error("adder_tree_sched: result written into a full FIFO");
        end
    end

    // Tag IDs and FIFO storage: payload only, qualified by the reset valids and count.
    // NOTE: storage arrays are not reset; their contents are never observed until written.
    always_ff @(posedge clk) begin
        tag_id_q <= tag_id_d;
        if (fifo_wr) begin
            mem_data_q[wr_ptr_q] <= tree_out;
            mem_id_q[wr_ptr_q]   <= tag_id_q[TREE_LAT];
        end
    end

    assign tree_in   = tree_in_q;
    assign res_valid = (fifo_count_q != '0);
    assign res_data  = mem_data_q[rd_ptr_q];
    assign res_id    = mem_id_q[rd_ptr_q];
    assign busy      = (inflight_q != '0) || (fifo_count_q != '0);

endmodule

// File: tb/tb_adder_tree_sched.sv
// Directed bench for adder_tree_sched: a behavioural fp32 adder tree with the
// integration latency feeds tree_out; expected grants, IDs and sums are
// hand-computed constants.
module tb_adder_tree_sched;

    localparam int NUM_REQ    = 4;
    localparam int NUM_IN     = 8;
    localparam int DW_DATA    = 32;
    localparam int DW_IN      = NUM_IN * DW_DATA;
    localparam int TREE_LAT   = 12;
    localparam int FIFO_DEPTH = 16;
    localparam int ID_W       = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*DW_IN-1:0] req_data;
    logic [DW_IN-1:0]         tree_in;
    logic [DW_DATA-1:0]       tree_out;
    logic                     res_valid;
    logic                     res_ready;
    logic [DW_DATA-1:0]       res_data;
    logic [ID_W-1:0]          res_id;
    logic                     busy;

    int n_cmp = 0;
    int n_err = 0;
    int hs, pops, first, last, cnt, bad;

    // Requester i sends eight lanes of (i+1).0; the tree sum is 8*(i+1).
    logic [31:0] lane_val [NUM_REQ] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    logic [31:0] exp_sum  [NUM_REQ] = '{32'h4100_0000, 32'h4180_0000, 32'h41C0_0000, 32'h4200_0000};
    logic [1:0]  t5_ids   [3]       = '{2'd2, 2'd0, 2'd2};
    logic [1:0]  t6_ids   [2]       = '{2'd1, 2'd3};

    adder_tree_sched #(
        .NUM_REQ(NUM_REQ), .NUM_IN(NUM_IN), .DW_DATA(DW_DATA), .DW_IN(DW_IN),
        .TREE_LAT(TREE_LAT), .FIFO_DEPTH(FIFO_DEPTH), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .tree_in(tree_in), .tree_out(tree_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic real fp32_to_real(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_fp32(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return 32'd0;
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fp_sum(input logic [DW_IN-1:0] v);
        real s;
        s = 0.0;
        for (int l = 0; l < NUM_IN; l++) s += fp32_to_real(v[l*DW_DATA +: DW_DATA]);
        return real_to_fp32(s);
    endfunction

    // Adder tree model: sum of the vector present after edge k appears after edge k+TREE_LAT.
    logic [31:0] tree_pipe [TREE_LAT];
    always @(posedge clk) begin
        tree_pipe[0] <= fp_sum(tree_in);
        for (int j = 1; j < TREE_LAT; j++) tree_pipe[j] <= tree_pipe[j-1];
    end
    assign tree_out = tree_pipe[TREE_LAT-1];

    task automatic check(input string tag, input logic [DW_IN-1:0] got, input logic [DW_IN-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        req_valid = '0;
        res_ready = 1'b0;
        rst       = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [DW_IN-1:0] onehot(input int idx);
        return DW_IN'(1) << (idx % NUM_REQ);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DW_IN +: DW_IN] = {NUM_IN{lane_val[i]}};
        rst       = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        step();
        step();

        // Reset values
        check("rst_ready", req_ready, 0);
        check("rst_tree_in", tree_in, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // Single request from req0: 8 x 1.0 -> 8.0, latency TREE_LAT+1 edges
        req_valid = 4'b0001;
        #1;
        check("t1_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        check("t1_tree_in", tree_in, {NUM_IN{32'h3F80_0000}});
        check("t1_busy_inflight", busy, 1);
        cnt = 0;
        while (!res_valid && cnt < 40) begin
            step();
            cnt++;
        end
        check("t1_latency", cnt, TREE_LAT + 1);
        check("t1_bubble", tree_in, 0);
        check("t1_data", res_data, 32'h4100_0000);
        check("t1_id", res_id, 0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("t1_res_valid_after_pop", res_valid, 0);
        check("t1_busy_after_pop", busy, 0);

        // Fairness: all valid, consumer always ready
        do_reset();
        req_valid = '1;
        res_ready = 1'b1;
        #1;
        hs = 0; pops = 0; first = -1; last = 0;
        for (int c = 0; c < 80 && pops < 12; c++) begin
            if (hs < 12) begin
                check("t2_grant", req_ready, onehot(hs));
                hs++;
            end else begin
                req_valid = '0;
            end
            if (res_valid) begin
                check("t2_id", res_id, pops % NUM_REQ);
                check("t2_data", res_data, exp_sum[pops % NUM_REQ]);
                if (first < 0) first = c;
                last = c;
                pops++;
            end
            step();
        end
        check("t2_pops", pops, 12);
        check("t2_no_gap", last - first, 11);

        // Backpressure: exactly FIFO_DEPTH handshakes, then drain in order and resume
        do_reset();
        req_valid = '1;
        #1;
        hs = 0;
        for (int c = 0; c < 40; c++) begin
            if (req_ready != '0) begin
                check("t3_grant", req_ready, onehot(hs));
                hs++;
            end
            step();
        end
        check("t3_handshakes", hs, FIFO_DEPTH);
        check("t3_res_valid_full", res_valid, 1);
        res_ready = 1'b1;
        #1;
        check("t3_stall_until_pop", req_ready, 0);
        pops = 0;
        for (int c = 0; c < 120 && pops < 24; c++) begin
            if (hs == 24) begin
                req_valid = '0;
            end else if (req_ready != '0) begin
                check("t3_grant_resume", req_ready, onehot(hs));
                hs++;
            end
            if (res_valid) begin
                check("t3_id", res_id, pops % NUM_REQ);
                check("t3_data", res_data, exp_sum[pops % NUM_REQ]);
                pops++;
            end
            step();
        end
        check("t3_pops", pops, 24);
        check("t3_busy_idle", busy, 0);

        // Full boundary: FIFO at 15, one inflight, write and pop on the same edge
        do_reset();
        req_valid = '1;
        repeat (28) step();
        check("t4_res_valid", res_valid, 1);
        check("t4_head_id", res_id, 0);
        res_ready = 1'b1;
        #1;
        check("t4_no_grant_same_cycle", req_ready, 0);
        step();
        res_ready = 1'b0;
        #1;
        check("t4_grant_next_cycle", req_ready, 4'b0001);
        step();
        check("t4_stall_again", req_ready, 0);
        req_valid = '0;
        res_ready = 1'b1;
        pops = 1;
        for (int c = 0; c < 40; c++) begin
            if (res_valid) begin
                check("t4_id", res_id, pops % NUM_REQ);
                pops++;
            end
            step();
        end
        check("t4_total_pops", pops, 17);

        // Pointer behaviour and bubbles
        do_reset();
        res_ready = 1'b1;
        req_valid = 4'b0100;
        #1;
        check("t5_grant_2", req_ready, 4'b0100);
        step();
        req_valid = 4'b0101;
        #1;
        check("t5_grant_0", req_ready, 4'b0001);
        step();
        req_valid = 4'b0100;
        #1;
        check("t5_grant_2_again", req_ready, 4'b0100);
        step();
        req_valid = '0;
        pops = 0;
        for (int c = 0; c < 40; c++) begin
            if (res_valid) begin
                if (pops < 3) begin
                    check("t5_id", res_id, t5_ids[pops]);
                    check("t5_data", res_data, exp_sum[t5_ids[pops]]);
                end
                pops++;
            end
            step();
        end
        check("t5_pops", pops, 3);

        // Reset mid-flight discards everything; first grant follows the reset pointer
        do_reset();
        req_valid = '1;
        #1;
        repeat (5) step();
        req_valid = '0;
        check("t6_busy_before_rst", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < TREE_LAT + 5; c++) begin
            if (res_valid || busy) bad++;
            step();
        end
        check("t6_quiet_after_rst", bad, 0);
        req_valid = 4'b1010;
        #1;
        check("t6_grant_1_first", req_ready, 4'b0010);
        step();
        req_valid = 4'b1000;
        #1;
        check("t6_grant_3", req_ready, 4'b1000);
        step();
        req_valid = '0;
        res_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 40; c++) begin
            if (res_valid) begin
                if (pops < 2) check("t6_id", res_id, t6_ids[pops]);
                pops++;
            end
            step();
        end
        check("t6_pops", pops, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adder_tree_sched.md
# adder_tree_sched

Round-robin scheduler that shares one fp32 adder tree (NUM_IN-input, fixed-latency, no backpressure) among NUM_REQ requesters. It arbitrates operand vectors onto the tree input and tracks each issued vector's requester ID through a tag pipeline matched to the tree latency. Sums are buffered in a result FIFO, and issue is credit-limited so that no tree result is ever dropped. The block sits between the tensor-core reduction clients and the adder tree instance.

## Interface
- NUM_REQ, 4, number of requesters (≥2)
- NUM_IN, 8, tree inputs per vector
- DW_DATA, 32, fp32 word width
- DW_IN, NUM_IN*DW_DATA, vector width
- TREE_LAT, 12, cycles from tree_in update edge to sum valid on tree_out (set at integration)
- FIFO_DEPTH, 16, result FIFO entries (≥TREE_LAT+2 for full throughput)
- ID_W, clog2(NUM_REQ), requester ID width
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester vector valid
- req_ready  out  NUM_REQ  one-hot grant; handshake when valid & ready
- req_data  in  NUM_REQ*DW_IN  requester i vector at [i*DW_IN +: DW_IN]
- tree_in  out  DW_IN  registered operand vector to tree
- tree_out  in  DW_DATA  tree sum
- res_valid  out  1  result FIFO non-empty
- res_ready  in  1  consumer accepts head
- res_data  out  DW_DATA  head sum
- res_id  out  ID_W  head requester ID
- busy  out  1  inflight≠0 or FIFO non-empty

## Operation
- Eligibility: issue is allowed only when inflight + fifo_count < FIFO_DEPTH, using registered values. A pop in the same cycle does not free a credit until the next cycle.
- Arbitration: round-robin. The search starts at ptr+1 mod NUM_REQ. The first valid requester is granted, and ptr is set to that index on grant. ptr resets to NUM_REQ-1, so index 0 wins first.
- req_ready is combinational from req_valid, ptr and eligibility. At most one bit is high, and never high without the matching req_valid.
- Requesters hold req_valid and req_data stable until the handshake.
- On grant, tree_in is loaded with the granted vector. With no grant, tree_in is loaded with all-zero (bubble).
- Tag pipeline: a {valid, id} shift register of depth TREE_LAT+1 is loaded at the same edge as tree_in. When the tag exits with valid=1, tree_out is written into the FIFO with that id. Bubbles are never written.
- inflight: +1 on grant, −1 on FIFO write; both in the same cycle leaves it unchanged. fifo_count: +1 on write, −1 on pop (res_valid & res_ready); both in the same cycle leaves it unchanged.
- The FIFO is first-word-fall-through. res_data and res_id are the head entry, and are don't-care while res_valid=0.
- Results leave in issue order, since the tree latency is fixed.
- Overflow is impossible by the credit rule. A write to a full FIFO is an assertion failure.

## Timing
- Reset values: req_ready=0, tree_in=0, res_valid=0, busy=0, ptr=NUM_REQ-1, all tag valids 0, inflight=0, fifo_count=0.
- Reset mid-operation: all in-flight tags and FIFO contents are discarded. Tree outputs arriving after reset are ignored. The first grant after reset follows the reset ptr.
- Handshake at edge k:
  - tree_in is updated at edge k.
  - The sum is present on tree_out during cycle (k+TREE_LAT, k+TREE_LAT+1).
  - The sum is written into the FIFO at edge k+TREE_LAT+1.
  - res_valid is high in the following cycle if the FIFO was empty.
- Total request-to-result latency: TREE_LAT+1 edges after the handshake edge.
- Throughput: one grant per cycle while credits remain.
- Credit stall: the FIFO_DEPTH-th outstanding vector blocks all req_ready until a pop has registered.

## Test plan
- Single request: req0 with 8×0x3F800000 → res_data=0x41000000, res_id=0, res_valid rising TREE_LAT+1 edges after handshake, busy falling after the pop.
- Fairness: all 4 req_valid held high, res_ready=1 → grants 0,1,2,3,0,… one per cycle, and res_id follows the same sequence with no gaps.
- Backpressure: 4 requesters valid, res_ready=0 → exactly 16 handshakes, then req_ready=0 permanently. Raising res_ready drains all 16 in order, then grants resume with no lost or duplicate IDs.
- Full boundary: FIFO at 15, inflight=1, a capture and a pop in the same cycle → fifo_count stays 15. No grant is issued that cycle; a grant is issued the next cycle.
- Pointer behaviour: req2 alone is granted, then req0 and req2 are both valid → grant goes to 0 next, then 2. Bubble cycles produce no FIFO writes.
- Reset mid-flight: 5 grants issued, rst asserted for 1 cycle → res_valid and busy stay 0 through TREE_LAT+5 cycles. A new req3 plus req1 request → req1 is granted first.
